// File: rtl/pio_stream_out_if.sv
// pio_stream_out_if -- bus bundle for pio_stream_out.
//
// Groups the Avalon-MM slave port (address, chipselect, write_n, writedata,
// readdata), the downstream stream port (out_data, out_valid, out_ready)
// and the low-water interrupt (irq).
//
// Stream handshake: a word transfers on every rising clk edge where
// out_valid and out_ready are both 1. out_valid never depends on out_ready,
// and out_data is stable while out_valid is high and out_ready is low.
//
// Modports:
//   master -- host/consumer side: drives the bus strobes and out_ready
//   slave  -- pio_stream_out side: drives readdata, the stream outputs, irq
interface pio_stream_out_if #(
  parameter int DATA_W = 20
);
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              irq;

  modport master (
    output address, chipselect, write_n, writedata, out_ready,
    input  readdata, out_data, out_valid, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata, out_ready,
    output readdata, out_data, out_valid, irq
  );
endinterface

// File: rtl/pio_stream_out.sv
// pio_stream_out -- Avalon-MM programmable output port with optional FIFO.
//
// Legacy mode (CONTROL.mode=0): a DATA write loads the hold register, which
// drives out_data directly; out_valid stays 0.
// Stream mode (CONTROL.mode=1): DATA writes push into a DEPTH-entry FIFO;
// the FIFO head drives out_data with out_valid = ~empty. Each popped word
// is also captured in the hold register so DATA reads show the last word
// delivered downstream.
//
// Register map (word address):
//   0 DATA    W: push / load hold     R: hold register
//   1 STATUS  W: bit10=1 clears overflow
//             R: [7:0] level, [8] empty, [9] full, [10] overflow
//   2 CONTROL W/R: [0] mode, [1] irq_en, [2] flush (write-1 pulse, reads 0)
//   3 THRESH  W/R: [7:0] low-water threshold
//
// Ports:
//   clk     -- clock, rising edge
//   reset_n -- asynchronous active-low reset
//   bus     -- pio_stream_out_if.slave (MM slave, stream source, irq)
module pio_stream_out #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  pio_stream_out_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic              mode;
  logic              irq_en;
  logic              overflow;
  logic [7:0]        thresh;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;

  logic wr;
  logic data_wr;
  logic status_wr;
  logic ctrl_wr;
  logic thresh_wr;
  logic flush;
  logic empty;
  logic full;
  logic push_req;
  logic push_ok;
  logic push_drop;
  logic pop;
  logic unused_writedata;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign data_wr   = wr & (bus.address == 2'd0);
  assign status_wr = wr & (bus.address == 2'd1);
  assign ctrl_wr   = wr & (bus.address == 2'd2);
  assign thresh_wr = wr & (bus.address == 2'd3);

  assign flush = ctrl_wr & bus.writedata[2];
  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

  // A push arriving with a flush is discarded outright (no overflow).
  // When full, a same-cycle pop frees the slot the push needs.
  assign pop       = bus.out_valid & bus.out_ready;
  assign push_req  = data_wr & mode & ~flush;
  assign push_ok   = push_req & (~full | pop);
  assign push_drop = push_req & full & ~pop;

  assign unused_writedata = ^bus.writedata;

  // Storage array carries no reset: only pointers and level define contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.writedata[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode     <= 1'b0;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
      thresh   <= 8'd0;
      hold     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
    end else begin
      if (ctrl_wr) begin
        mode   <= bus.writedata[0];
        irq_en <= bus.writedata[1];
      end
      if (thresh_wr) thresh <= bus.writedata[7:0];

      if (push_drop)                          overflow <= 1'b1;
      else if (status_wr && bus.writedata[10]) overflow <= 1'b0;

      // Legacy DATA write and stream pop are exclusive (pop needs mode=1).
      if (data_wr && !mode) hold <= bus.writedata[DATA_W-1:0];
      else if (pop)         hold <= mem[rd_ptr];

      if (flush) begin
        // A word handshaken on the flush edge is still delivered (hold
        // captures it above); everything else queued is discarded.
        rd_ptr <= wr_ptr;
        level  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
        case ({push_ok, pop})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: level <= level;
        endcase
      end
    end
  end

  assign bus.out_valid = mode & ~empty;
  assign bus.out_data  = mode ? mem[rd_ptr] : hold;
  assign bus.irq       = irq_en & mode & (8'(level) <= thresh);

  always_comb begin
    bus.readdata = 32'd0;
    case (bus.address)
      2'd0: bus.readdata = 32'(hold);
      2'd1: bus.readdata = {21'd0, overflow, full, empty, 8'(level)};
      2'd2: bus.readdata = {30'd0, irq_en, mode};
      2'd3: bus.readdata = {24'd0, thresh};
      default: bus.readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_pio_stream_out.sv
module tb_pio_stream_out;

  localparam int W = 20;

  logic clk;
  logic reset_n;

  pio_stream_out_if #(.DATA_W(W)) bus ();

  pio_stream_out #(.DATA_W(W), .DEPTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted stream word must match the queue head.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL stream_unexpected: got 0x%0h expected no word", bus.out_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          n_fail++;
          $display("FAIL stream_word: got 0x%0h expected 0x%0h", bus.out_data, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers start and end at posedge+1.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk); #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #2;
    d = bus.readdata;
    @(posedge clk); #1;
    bus.chipselect = 1'b0;
  endtask

  task automatic check_read(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic stream_write(input logic [W-1:0] d, input bit accepted);
    if (accepted) exp_q.push_back(d);
    bus_write(2'd0, 32'(d));
  endtask

  task automatic drain(input int cycles);
    bus.out_ready = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n        = 1'b0;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    bus.out_ready  = 1'b0;

    // Reset state, observed while reset is held and after release.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_irq", 32'(bus.irq), 32'd0);
    check_read("rst_status", 2'd1, 32'h100);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_read("rst_control", 2'd2, 32'h0);
    check_read("rst_thresh", 2'd3, 32'h0);
    check_read("rst_data", 2'd0, 32'h0);

    // Legacy mode.
    bus_write(2'd0, 32'hABCDE);
    check("legacy_out_data", 32'(bus.out_data), 32'hABCDE);
    check("legacy_out_valid", 32'(bus.out_valid), 32'd0);
    check_read("legacy_data_rd", 2'd0, 32'hABCDE);
    check_read("legacy_fifo_untouched", 2'd1, 32'h100);

    // Stream order and one-cycle latency.
    bus_write(2'd2, 32'h1);
    check("stream_empty_valid", 32'(bus.out_valid), 32'd0);
    stream_write(20'h1, 1'b1);
    check("stream_latency_valid", 32'(bus.out_valid), 32'd1);
    stream_write(20'h2, 1'b1);
    stream_write(20'h3, 1'b1);
    check_read("stream_level3", 2'd1, 32'h003);
    drain(3);
    check("stream_drained_q", 32'(exp_q.size()), 32'd0);
    check("stream_drained_valid", 32'(bus.out_valid), 32'd0);
    check_read("stream_drained_status", 2'd1, 32'h100);
    check_read("stream_hold_last", 2'd0, 32'h3);

    // Overflow: 9 writes into 8 entries, 9th dropped.
    for (int i = 0; i < 9; i++) stream_write(20'(32'h10 + i), i < 8);
    check_read("ovf_status", 2'd1, 32'h608);
    bus_write(2'd1, 32'h400);
    check_read("ovf_cleared", 2'd1, 32'h208);

    // Full with simultaneous push and pop.
    bus.out_ready = 1'b1;
    stream_write(20'h99, 1'b1);
    bus.out_ready = 1'b0;
    check_read("fullpp_status", 2'd1, 32'h208);
    drain(8);
    check("fullpp_drained_q", 32'(exp_q.size()), 32'd0);
    check_read("fullpp_last_out", 2'd0, 32'h99);

    // Flush and low-water irq.
    bus_write(2'd3, 32'h2);
    bus_write(2'd2, 32'h3);
    check("irq_empty", 32'(bus.irq), 32'd1);
    for (int i = 0; i < 5; i++) stream_write(20'(32'h31 + i), 1'b1);
    check("irq_level5", 32'(bus.irq), 32'd0);
    check_read("flush_pre_status", 2'd1, 32'h005);
    bus_write(2'd2, 32'h7);
    exp_q.delete();
    check("irq_after_flush", 32'(bus.irq), 32'd1);
    check_read("flush_status", 2'd1, 32'h100);
    check_read("flush_ctrl_rd", 2'd2, 32'h3);
    check_read("flush_hold_kept", 2'd0, 32'h99);

    // Contents survive a trip through legacy mode.
    stream_write(20'h21, 1'b1);
    stream_write(20'h22, 1'b1);
    bus_write(2'd2, 32'h2);
    check("legacy_again_valid", 32'(bus.out_valid), 32'd0);
    check("legacy_again_irq", 32'(bus.irq), 32'd0);
    check("legacy_again_data", 32'(bus.out_data), 32'h99);
    bus_write(2'd0, 32'h55);
    check("legacy_load", 32'(bus.out_data), 32'h55);
    check_read("legacy_keeps_fifo", 2'd1, 32'h002);
    bus_write(2'd2, 32'h1);
    check("reenter_valid", 32'(bus.out_valid), 32'd1);
    check("reenter_head", 32'(bus.out_data), 32'h21);
    drain(2);
    check("reenter_drained_q", 32'(exp_q.size()), 32'd0);
    check_read("reenter_hold", 2'd0, 32'h22);

    // Reset in the middle of a stream with a pending handshake.
    for (int i = 0; i < 4; i++) stream_write(20'(32'h41 + i), 1'b1);
    check_read("midrst_level4", 2'd1, 32'h004);
    bus.out_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_data", 32'(bus.out_data), 32'd0);
    check_read("midrst_status", 2'd1, 32'h100);
    check_read("midrst_ctrl", 2'd2, 32'h0);
    bus.out_ready = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_valid", 32'(bus.out_valid), 32'd0);
    check_read("postrst_status", 2'd1, 32'h100);

    repeat (2) @(posedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
